// File: rtl/mmu_sum_deskew.sv
// De-skews the systolic MMU output columns and queues aligned rows in a show-ahead FIFO.
// Optional feature macro: MMU_OUT_RELU_EN (rectify negative column sums at the aligned stage).
module mmu_sum_deskew #(
  parameter int WIDTH_HEIGHT = 4,
  parameter int SUM_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [WIDTH_HEIGHT-1:0]           colValid,
  input  logic [SUM_WIDTH*WIDTH_HEIGHT-1:0] sumIn,
  output logic [SUM_WIDTH*WIDTH_HEIGHT-1:0] rowOut,
  output logic                              rowValid,
  input  logic                              rowReady,
  output logic [$clog2(FIFO_DEPTH):0]       rowCount,
  output logic                              full,
  output logic                              overflow,
  output logic                              skewErr
);

  localparam int RW = SUM_WIDTH * WIDTH_HEIGHT;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [SUM_WIDTH-1:0]    w_dly_data [WIDTH_HEIGHT];
  logic [WIDTH_HEIGHT-1:0] w_dly_valid;
  logic [RW-1:0]           w_row;

  // Column c waits WIDTH_HEIGHT-1-c cycles so every column of a row lines up with the last one.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_col
      localparam int D = WIDTH_HEIGHT - 1 - gi;
      if (D == 0) begin : g_direct
        assign w_dly_data[gi]  = sumIn[gi*SUM_WIDTH +: SUM_WIDTH];
        assign w_dly_valid[gi] = colValid[gi];
      end else begin : g_delay
        logic [SUM_WIDTH-1:0] r_data [D];
        logic [D-1:0]         r_valid;
        always_ff @(posedge clk) begin
          if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < D; k++) r_data[k] <= '0;
          end else begin
            r_data[0]  <= sumIn[gi*SUM_WIDTH +: SUM_WIDTH];
            r_valid[0] <= colValid[gi];
            for (int k = 1; k < D; k++) begin
              r_data[k]  <= r_data[k-1];
              r_valid[k] <= r_valid[k-1];
            end
          end
        end
        assign w_dly_data[gi]  = r_data[D-1];
        assign w_dly_valid[gi] = r_valid[D-1];
      end
`ifdef MMU_OUT_RELU_EN
      assign w_row[gi*SUM_WIDTH +: SUM_WIDTH] =
        w_dly_data[gi][SUM_WIDTH-1] ? '0 : w_dly_data[gi];
`else
      assign w_row[gi*SUM_WIDTH +: SUM_WIDTH] = w_dly_data[gi];
`endif
    end
  endgenerate

  logic w_aligned_valid, w_aligned_any, w_push, w_pop;
  logic [RW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow, r_skew_err;

  assign w_aligned_valid = &w_dly_valid;
  assign w_aligned_any   = |w_dly_valid;
  assign rowValid        = (r_count != '0);
  assign full            = (r_count == CW'(FIFO_DEPTH));
  assign w_pop           = rowValid && rowReady;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign w_push          = w_aligned_valid && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_skew_err <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_row;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_aligned_valid && full && !w_pop) r_overflow <= 1'b1;
      if (w_aligned_any && !w_aligned_valid) r_skew_err <= 1'b1;
    end
  end

  assign rowOut   = rowValid ? r_mem[r_rd_ptr] : '0;
  assign rowCount = r_count;
  assign overflow = r_overflow;
  assign skewErr  = r_skew_err;

endmodule

// File: tb/tb_mmu_sum_deskew.sv
// Directed self-checking bench for mmu_sum_deskew (4 columns x 16 bits, 8-deep FIFO).
module tb_mmu_sum_deskew;
  localparam int W  = 4;
  localparam int SW = 16;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  colValid;
  logic [W*SW-1:0] sumIn;
  logic [W*SW-1:0] rowOut;
  logic          rowValid;
  logic          rowReady;
  logic [3:0]    rowCount;
  logic          full, overflow, skewErr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mmu_sum_deskew #(.WIDTH_HEIGHT(W), .SUM_WIDTH(SW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .colValid(colValid), .sumIn(sumIn),
    .rowOut(rowOut), .rowValid(rowValid), .rowReady(rowReady), .rowCount(rowCount),
    .full(full), .overflow(overflow), .skewErr(skewErr)
  );

  function automatic logic [W*SW-1:0] mkrow(input logic [15:0] base, input int r);
    logic [W*SW-1:0] v;
    for (int c = 0; c < W; c++) v[c*SW +: SW] = base + 16'(32'h1000 * r + c);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1; colValid = '0; sumIn = '0; rowReady = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Drives n skewed rows (row index r0..r0+n-1); one (row,col) can be suppressed.
  task automatic send_rows(input int n, input logic [15:0] base, input int r0,
                           input int skip_r, input int skip_c, input bit rdy_last);
    for (int k = 0; k < n + W - 1; k++) begin
      colValid = '0; sumIn = '0;
      for (int c = 0; c < W; c++) begin
        int ri;
        ri = k - c;
        if (ri >= 0 && ri < n && !(ri == skip_r && c == skip_c)) begin
          colValid[c] = 1'b1;
          sumIn[c*SW +: SW] = base + 16'(32'h1000 * (r0 + ri) + c);
        end
      end
      if (rdy_last && k == n + W - 2) rowReady = 1'b1;
      step();
    end
    colValid = '0; sumIn = '0;
    if (rdy_last) rowReady = 1'b0;
  endtask

  task automatic drain_check(input string name, input logic [15:0] base, input int r0,
                             input int n, input int skip);
    int r;
    r = r0;
    rowReady = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (r == skip) r++;
      n_tests++;
      if (rowValid !== 1'b1 || rowOut !== mkrow(base, r)) begin
        n_fail++;
        $display("FAIL %s row%0d: rowValid=%0b rowOut=%h expected rowValid=1 rowOut=%h",
                 name, r, rowValid, rowOut, mkrow(base, r));
      end else $display("[TB] %s row%0d ok rowOut=%h", name, r, rowOut);
      step();
      r++;
    end
    rowReady = 1'b0;
    n_tests++;
    if (rowValid !== 1'b0 || rowCount !== 4'd0) begin
      n_fail++;
      $display("FAIL %s empty_after_drain: rowValid=%0b rowCount=%0d expected 0/0",
               name, rowValid, rowCount);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++;
    if (rowValid !== 1'b0 || rowOut !== '0 || rowCount !== 4'd0 || full !== 1'b0 ||
        overflow !== 1'b0 || skewErr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rowValid=%0b rowOut=%h rowCount=%0d full=%0b ovf=%0b skew=%0b expected all 0",
               rowValid, rowOut, rowCount, full, overflow, skewErr);
    end else $display("[TB] reset_state ok");
    rowReady = 1'b1;
    step(); step();
    n_tests++;
    if (rowValid !== 1'b0 || rowCount !== 4'd0) begin
      n_fail++;
      $display("FAIL ready_when_empty: rowValid=%0b rowCount=%0d expected 0/0", rowValid, rowCount);
    end
    rowReady = 1'b0;
  endtask

  task automatic test_single_row();
    logic [W*SW-1:0] exp_row;
    apply_reset();
    exp_row = 64'h0103_0102_0101_0100;
    rowReady = 1'b1;
    for (int k = 0; k < W; k++) begin
      colValid = '0; sumIn = '0;
      colValid[k] = 1'b1;
      sumIn[k*SW +: SW] = 16'h0100 + 16'(k);
      step();
      n_tests++;
      if (k < W - 1) begin
        if (rowValid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early k=%0d: rowValid=%0b expected 0", k, rowValid);
        end
      end else if (rowValid !== 1'b1 || rowOut !== exp_row) begin
        n_fail++;
        $display("FAIL single_row: rowValid=%0b rowOut=%h expected 1/%h", rowValid, rowOut, exp_row);
      end else $display("[TB] single_row ok rowOut=%h", rowOut);
    end
    colValid = '0; sumIn = '0;
    step();
    n_tests++;
    if (rowValid !== 1'b0 || rowCount !== 4'd0) begin
      n_fail++;
      $display("FAIL single_pulse: rowValid=%0b rowCount=%0d expected 0/0", rowValid, rowCount);
    end
    rowReady = 1'b0;
  endtask

  task automatic test_burst();
    apply_reset();
    send_rows(4, 16'h0000, 0, -1, -1, 1'b0);
    n_tests++;
    if (rowCount !== 4'd4) begin
      n_fail++;
      $display("FAIL burst_count: rowCount=%0d expected 4", rowCount);
    end else $display("[TB] burst_count ok rowCount=4");
    drain_check("burst", 16'h0000, 0, 4, -1);
  endtask

  task automatic test_overflow();
    apply_reset();
    send_rows(9, 16'h0000, 1, -1, -1, 1'b0);
    n_tests++;
    if (full !== 1'b1 || rowCount !== 4'd8 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state: full=%0b rowCount=%0d ovf=%0b expected 1/8/1",
               full, rowCount, overflow);
    end else $display("[TB] overflow_state ok");
    drain_check("overflow", 16'h0000, 1, 8, -1);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: ovf=%0b expected 1", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    send_rows(8, 16'h0000, 0, -1, -1, 1'b0);
    n_tests++;
    if (full !== 1'b1 || rowCount !== 4'd8) begin
      n_fail++;
      $display("FAIL full_fill: full=%0b rowCount=%0d expected 1/8", full, rowCount);
    end
    send_rows(1, 16'h0000, 8, -1, -1, 1'b1);
    n_tests++;
    if (rowCount !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop: rowCount=%0d ovf=%0b full=%0b expected 8/0/1",
               rowCount, overflow, full);
    end else $display("[TB] full_push_pop ok rowCount=8");
    drain_check("full_pp", 16'h0000, 1, 8, -1);
  endtask

  task automatic test_skew_err();
    apply_reset();
    send_rows(3, 16'h0300, 0, 1, 2, 1'b0);
    n_tests++;
    if (skewErr !== 1'b1 || rowCount !== 4'd2) begin
      n_fail++;
      $display("FAIL skew_err: skew=%0b rowCount=%0d expected 1/2", skewErr, rowCount);
    end else $display("[TB] skew_err ok");
    drain_check("skew", 16'h0300, 0, 2, 1);
  endtask

  task automatic test_reset_midrow();
    apply_reset();
    send_rows(3, 16'h0000, 0, -1, -1, 1'b0);
    colValid = 4'b0001; sumIn = '0; sumIn[0 +: SW] = 16'h3000;
    step();
    colValid = 4'b0010; sumIn = '0; sumIn[SW +: SW] = 16'h3001;
    step();
    reset = 1'b1; colValid = '0; sumIn = '0;
    step();
    n_tests++;
    if (rowValid !== 1'b0 || rowCount !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_midrow: rowValid=%0b rowCount=%0d expected 0/0", rowValid, rowCount);
    end else $display("[TB] reset_midrow ok");
    reset = 1'b0;
    for (int i = 0; i < W; i++) step();
    n_tests++;
    if (skewErr !== 1'b0 || rowCount !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_flush: skew=%0b rowCount=%0d expected 0/0", skewErr, rowCount);
    end
    send_rows(1, 16'h0000, 5, -1, -1, 1'b0);
    drain_check("post_reset", 16'h0000, 5, 1, -1);
  endtask

  task automatic test_relu();
    logic [W*SW-1:0] in_row, exp_row;
    apply_reset();
    in_row = 64'h7FFF_8000_0005_FFFF;
`ifdef MMU_OUT_RELU_EN
    exp_row = 64'h7FFF_0000_0005_0000;
`else
    exp_row = in_row;
`endif
    for (int k = 0; k < W; k++) begin
      colValid = '0; sumIn = '0;
      colValid[k] = 1'b1;
      sumIn[k*SW +: SW] = in_row[k*SW +: SW];
      step();
    end
    colValid = '0; sumIn = '0;
    n_tests++;
    if (rowValid !== 1'b1 || rowOut !== exp_row) begin
      n_fail++;
      $display("FAIL relu_row: rowValid=%0b rowOut=%h expected 1/%h", rowValid, rowOut, exp_row);
    end else $display("[TB] relu_row ok rowOut=%h", rowOut);
  endtask

  initial begin
    reset = 1'b1; colValid = '0; sumIn = '0; rowReady = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_row();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_skew_err();
    test_reset_midrow();
    test_relu();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
